// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// The op codes mirror the decode stage; codes 3'b110 and 3'b111 are reserved.
package mdu_pkg;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    localparam int         ITER_COUNT = 32;
    localparam logic [4:0] LAST_ITER  = 5'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Multiply and divide ops all have op[2] clear.
    function automatic logic is_muldiv(input logic [2:0] op_v);
        return (op_v[2] == 1'b0);
    endfunction

    // MULT and DIV treat their operands as two's complement.
    function automatic logic is_signed_op(input logic [2:0] op_v);
        return (op_v == MULT) || (op_v == DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_adj.sv
// Conditional two's-complement negation: takes magnitudes of signed operands at
// capture time and applies the sign fixup to results in FIN.
module mdu_sign_adj #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] result_o
);

    assign result_o = negate_i ? ((~value_i) + WIDTH'(1'b1)) : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO: 33-cycle MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO. Handshake: start is a level request that is acted on only
// on an edge where the unit is IDLE or finishing (FIN); while busy=1 the requester
// must hold it. done pulses for one cycle when hi/lo carry a new mul/div result.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] work_q, work_d;
    logic [31:0] opnd_b_q, opnd_b_d;
    logic        is_div_q, is_div_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_diff_q, sign_diff_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        can_accept;
    logic        take_op;
    logic        take_mt;
    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_next;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // FIN also accepts a request so a new op can start back-to-back with a result.
    assign can_accept = (state_q == IDLE) || (state_q == FIN);
    assign take_op    = start && !cancel && can_accept && is_muldiv(op);
    assign take_mt    = start && !cancel && can_accept && ((op == MTHI) || (op == MTLO));
    assign signed_op  = is_signed_op(op);

    mdu_sign_adj #(.WIDTH(32)) u_adj_a (
        .value_i  (a),
        .negate_i (signed_op && a[31]),
        .result_o (a_mag)
    );

    mdu_sign_adj #(.WIDTH(32)) u_adj_b (
        .value_i  (b),
        .negate_i (signed_op && b[31]),
        .result_o (b_mag)
    );

    // Shift-add step: work holds {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_b_q} : 33'd0);
    assign mul_next = {mul_sum, work_q[31:1]};

    // Restoring step: work holds {remainder, dividend bits shifting into quotient}.
    assign div_shift = {work_q[63:32], work_q[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_b_q};
    assign div_next  = div_diff[33] ? {div_shift[31:0], work_q[30:0], 1'b0}
                                    : {div_diff[31:0],  work_q[30:0], 1'b1};

    mdu_sign_adj #(.WIDTH(64)) u_adj_prod (
        .value_i  (work_q),
        .negate_i (sign_diff_q),
        .result_o (prod_fix)
    );

    mdu_sign_adj #(.WIDTH(32)) u_adj_quo (
        .value_i  (work_q[31:0]),
        .negate_i (sign_diff_q),
        .result_o (quo_fix)
    );

    mdu_sign_adj #(.WIDTH(32)) u_adj_rem (
        .value_i  (work_q[63:32]),
        .negate_i (sign_a_q),
        .result_o (rem_fix)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        work_d      = work_q;
        opnd_b_d    = opnd_b_q;
        is_div_d    = is_div_q;
        sign_a_d    = sign_a_q;
        sign_diff_d = sign_diff_q;
        div_zero_d  = div_zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;

        case (state_q)
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                    count_d = 5'd0;
                end else begin
                    work_d  = is_div_q ? div_next : mul_next;
                    count_d = count_q + 5'd1;
                    if (count_q == LAST_ITER) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                count_d = 5'd0;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // A zero divisor leaves the dividend in the remainder already.
                        hi_d = rem_fix;
                        lo_d = div_zero_q ? 32'hFFFF_FFFF : quo_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take_op) begin
            state_d     = CALC;
            count_d     = 5'd0;
            work_d      = {32'd0, a_mag};
            opnd_b_d    = b_mag;
            is_div_d    = op[1];
            sign_a_d    = signed_op && a[31];
            sign_diff_d = signed_op && (a[31] ^ b[31]);
            div_zero_d  = (b == 32'd0);
        end

        // A move issued on the finishing edge is younger, so it wins over the result.
        if (take_mt) begin
            if (op == MTHI) begin
                hi_d = a;
            end else begin
                lo_d = a;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= 5'd0;
            work_q      <= 64'd0;
            opnd_b_q    <= 32'd0;
            is_div_q    <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_diff_q <= 1'b0;
            div_zero_q  <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            work_q      <= work_d;
            opnd_b_q    <= opnd_b_d;
            is_div_q    <= is_div_d;
            sign_a_q    <= sign_a_d;
            sign_diff_q <= sign_diff_d;
            div_zero_q  <= div_zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, 33-cycle latency,
// cancel, ignored requests and asynchronous reset.
module tb_mult_div_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests;
    int fails;

    mult_div_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one mul/div op, then follows it edge by edge until done or a 40-edge budget.
    // With intrude set, conflicting MULT requests are pulsed at cycles 5 and 20.
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit intrude, input string tag);
        int lat;
        int busy_gaps;
        bit seen;
        lat = 0;
        busy_gaps = 0;
        seen = 1'b0;
        op = o;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_e0"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 40 && !seen; i++) begin
            if (intrude && (i == 5 || i == 20)) begin
                start = 1'b1;
                op = OP_MULT;
                a = 32'hFFFF_FFFD;
                b = 32'd7;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                seen = 1'b1;
                lat = i;
            end else if (!busy) begin
                busy_gaps++;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_busy_gaps"}, 32'(busy_gaps), 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        tick();
        check({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_seen;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        cancel = 1'b0;
        op = 3'b000;
        a = 32'd0;
        b = 32'd0;

        // Reset state
        #3;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Multiply
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg3x7");

        // Divide and its edge cases
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg7by2");
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");
        run_op(OP_DIVU, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b0, "divu_by0");

        // Cancel at cycle 10 of a DIVU: hi/lo keep 0x64 / 0xFFFFFFFF
        op = OP_DIVU;
        a = 32'd50;
        b = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_seen = 0;
        repeat (9) begin
            tick();
            if (done) done_seen++;
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        if (done) done_seen++;
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_hi", hi, 32'h0000_0064);
        check("cancel_lo", lo, 32'hFFFF_FFFF);
        op = OP_MTLO;
        a = 32'h1234_5678;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (done) done_seen++;
        check("mtlo_lo", lo, 32'h1234_5678);
        check("mtlo_hi_kept", hi, 32'h0000_0064);
        check("mtlo_busy", 32'(busy), 32'd0);
        repeat (35) begin
            tick();
            if (done) done_seen++;
        end
        check("cancel_no_done", 32'(done_seen), 32'd0);
        check("cancel_idle_busy", 32'(busy), 32'd0);

        // Requests during MULTU are ignored; result is 0x12345 * 0x1000
        run_op(OP_MULTU, 32'h0001_2345, 32'h0000_1000, 32'h0000_0000, 32'h1234_5000, 1'b1, "multu_intrude");

        // MTHI, single edge, no busy/done
        op = OP_MTHI;
        a = 32'hCAFE_F00D;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mthi_hi", hi, 32'hCAFE_F00D);
        check("mthi_lo_kept", lo, 32'h1234_5000);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_done", 32'(done), 32'd0);

        // Reserved op is ignored
        op = OP_RSVD;
        a = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_hi", hi, 32'hCAFE_F00D);
        check("rsvd_lo", lo, 32'h1234_5000);

        // Cancel beats a simultaneous start in IDLE
        op = OP_MULT;
        a = 32'd5;
        b = 32'd6;
        start = 1'b1;
        cancel = 1'b1;
        tick();
        start = 1'b0;
        cancel = 1'b0;
        check("cancel_start_busy", 32'(busy), 32'd0);
        tick();
        check("cancel_start_busy2", 32'(busy), 32'd0);
        check("cancel_start_lo", lo, 32'h1234_5000);

        // Asynchronous reset mid-CALC
        op = OP_MULT;
        a = 32'd5;
        b = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_hi", hi, 32'd0);
        check("async_rst_lo", lo, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, "mult_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
